// File: rtl/deadlock_watchdog.sv
// Deadlock watchdog: debounces the deadlock monitor's block flag over THRESH
// consecutive cycles, then emits one onset report beat and halts until cleared.
`timescale 1ns/1ps

module deadlock_watchdog #(
    parameter int AXIS_W = 12,
    parameter int IDLE_W = 21,
    parameter int BLK_W  = 16,
    parameter int THRESH = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              block_in,
    input  logic [AXIS_W-1:0] axis_block_sigs,
    input  logic [IDLE_W-1:0] inst_idle_sigs,
    input  logic [BLK_W-1:0]  inst_block_sigs,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_cycle,
    output logic [AXIS_W-1:0] rpt_axis,
    output logic [IDLE_W-1:0] rpt_idle,
    output logic [BLK_W-1:0]  rpt_blk,
    output logic              deadlock,
    output logic [7:0]        glitch_cnt
);

    localparam int RUN_W = $clog2(THRESH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PENDING,
        S_REPORT,
        S_HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [7:0]         glitch_q, glitch_d;
    logic [CNT_W-1:0]   cyc_cnt_q;

    // Onset snapshot of the episode in progress; only promoted to the report
    // outputs once the episode qualifies, so aborted episodes never leak out.
    logic [CNT_W-1:0]   cap_cycle_q;
    logic [AXIS_W-1:0]  cap_axis_q;
    logic [IDLE_W-1:0]  cap_idle_q;
    logic [BLK_W-1:0]   cap_blk_q;

    logic [CNT_W-1:0]   rpt_cycle_q;
    logic [AXIS_W-1:0]  rpt_axis_q;
    logic [IDLE_W-1:0]  rpt_idle_q;
    logic [BLK_W-1:0]   rpt_blk_q;

    logic               capture;
    logic               load_rpt;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        glitch_d  = glitch_q;
        capture   = 1'b0;
        load_rpt  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    run_cnt_d = '0;
                end else if (block_in) begin
                    capture   = 1'b1;
                    run_cnt_d = RUN_W'(1);
                    if (THRESH == 1) begin
                        state_d  = S_REPORT;
                        load_rpt = 1'b1;
                    end else begin
                        state_d = S_PENDING;
                    end
                end
            end
            S_PENDING: begin
                if (!enable) begin
                    state_d   = S_IDLE;
                    run_cnt_d = '0;
                end else if (block_in) begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                    if (run_cnt_q == RUN_W'(THRESH - 1)) begin
                        state_d  = S_REPORT;
                        load_rpt = 1'b1;
                    end
                end else begin
                    state_d   = S_ARMED;
                    run_cnt_d = '0;
                    if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
                end
            end
            S_REPORT: begin
                if (rpt_ready) state_d = S_HALTED;
            end
            S_HALTED: begin
                if (clear) begin
                    state_d   = S_ARMED;
                    run_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                run_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            glitch_q  <= '0;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            glitch_q  <= glitch_d;
            if (enable && (cyc_cnt_q != '1)) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: snapshot and report registers are plain flops, not memories, so they are reset like any other state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_cycle_q <= '0;
            cap_axis_q  <= '0;
            cap_idle_q  <= '0;
            cap_blk_q   <= '0;
        end else if (capture) begin
            cap_cycle_q <= cyc_cnt_q;
            cap_axis_q  <= axis_block_sigs;
            cap_idle_q  <= inst_idle_sigs;
            cap_blk_q   <= inst_block_sigs;
        end
    end

    // With THRESH==1 onset and promotion share one edge, so bypass the snapshot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cycle_q <= '0;
            rpt_axis_q  <= '0;
            rpt_idle_q  <= '0;
            rpt_blk_q   <= '0;
        end else if (load_rpt) begin
            rpt_cycle_q <= capture ? cyc_cnt_q       : cap_cycle_q;
            rpt_axis_q  <= capture ? axis_block_sigs : cap_axis_q;
            rpt_idle_q  <= capture ? inst_idle_sigs  : cap_idle_q;
            rpt_blk_q   <= capture ? inst_block_sigs : cap_blk_q;
        end
    end

    assign rpt_valid  = (state_q == S_REPORT);
    assign deadlock   = (state_q == S_REPORT) || (state_q == S_HALTED);
    assign glitch_cnt = glitch_q;
    assign rpt_cycle  = rpt_cycle_q;
    assign rpt_axis   = rpt_axis_q;
    assign rpt_idle   = rpt_idle_q;
    assign rpt_blk    = rpt_blk_q;

endmodule
